mem_rd_arbiter: RTL and testbench

//  Shares the single memory read-burst channel between I-cache (port 0) and D-cache (port 1) refills.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 30 +++
 rtl/mem_rd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Purpose: shared types and constants for the cache refill read path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents: one-hot arbiter states, requester ids, default burst length.
package cache_pkg;

   // One-hot arbiter state encoding.
   typedef enum logic [2:0] {
      ARB_IDLE = 3'b001,
      ARB_REQ  = 3'b010,
      ARB_DATA = 3'b100
   } arb_state_t;

   // Requester ids; also the bit index of each requester in a valid vector.
   localparam logic REQ_IC = 1'b0;
   localparam logic REQ_DC = 1'b1;

   localparam int CACHE_BURST_LEN = 8;

endpackage

// File: rtl/rr_pick2.sv
// Purpose: two-way round-robin winner selection.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   valid      [1:0] request valids, index = requester id
//   last_grant       id of the requester served most recently
//   win              at least one requester is valid
//   grant_id         id of the chosen requester (REQ_IC when nothing is valid)
module rr_pick2
   import cache_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       win,
   output logic       grant_id
);

   always_comb begin
      win      = |valid;
      grant_id = REQ_IC;
      if (&valid) begin
         // Tie: hand the channel to whoever did not have it last.
         grant_id = ~last_grant;
      end else if (valid[1]) begin
         grant_id = REQ_DC;
      end
   end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Purpose: shares one memory read-burst channel between I-cache (port 0) and D-cache (port 1).
// Latency: 1 idle cycle per burst for arbitration; request and beats pass through combinationally.
// Backpressure: mem req_ready drives the granted req_ready; granted rsp_ready drives mem rsp_ready.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   ic_rd_req_* / dc_rd_req_*     cache read requests (valid, addr, ready)
//   ic_rd_rsp_* / dc_rd_rsp_*     beats back to the caches (valid, data, last, ready)
//   mem_rd_req_*                  request to memory (valid, addr, ready)
//   mem_rd_rsp_*                  beats from memory (valid, data, last, ready)
//   busy                          a grant is held (state is not IDLE)
module mem_rd_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = CACHE_BURST_LEN
)
(
   input  logic              clk,
   input  logic              rst,

   input  logic              ic_rd_req_valid,
   input  logic [ADDR_W-1:0] ic_rd_req_addr,
   output logic              ic_rd_req_ready,
   output logic              ic_rd_rsp_valid,
   output logic [DATA_W-1:0] ic_rd_rsp_data,
   output logic              ic_rd_rsp_last,
   input  logic              ic_rd_rsp_ready,

   input  logic              dc_rd_req_valid,
   input  logic [ADDR_W-1:0] dc_rd_req_addr,
   output logic              dc_rd_req_ready,
   output logic              dc_rd_rsp_valid,
   output logic [DATA_W-1:0] dc_rd_rsp_data,
   output logic              dc_rd_rsp_last,
   input  logic              dc_rd_rsp_ready,

   output logic              mem_rd_req_valid,
   output logic [ADDR_W-1:0] mem_rd_req_addr,
   input  logic              mem_rd_req_ready,
   input  logic              mem_rd_rsp_valid,
   input  logic [DATA_W-1:0] mem_rd_rsp_data,
   input  logic              mem_rd_rsp_last,
   output logic              mem_rd_rsp_ready,

   output logic              busy
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              grant_id;
   logic              last_grant;
   logic [BEAT_W-1:0] beat_cnt;

   logic              pick_win;
   logic              pick_id;
   logic              req_hs;
   logic              rsp_hs;

   rr_pick2 u_pick (
      .valid      ({dc_rd_req_valid, ic_rd_req_valid}),
      .last_grant (last_grant),
      .win        (pick_win),
      .grant_id   (pick_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus all handshake/datapath muxing. Everything not owned by
   // the current state stays at zero so the idle bus is quiet.
   always_comb begin
      state_nxt        = state;
      req_hs           = 1'b0;
      rsp_hs           = 1'b0;
      mem_rd_req_valid = 1'b0;
      mem_rd_req_addr  = '0;
      mem_rd_rsp_ready = 1'b0;
      ic_rd_req_ready  = 1'b0;
      ic_rd_rsp_valid  = 1'b0;
      ic_rd_rsp_data   = '0;
      ic_rd_rsp_last   = 1'b0;
      dc_rd_req_ready  = 1'b0;
      dc_rd_rsp_valid  = 1'b0;
      dc_rd_rsp_data   = '0;
      dc_rd_rsp_last   = 1'b0;

      case (state)
         ARB_IDLE: begin
            if (pick_win) begin
               state_nxt = ARB_REQ;
            end
         end

         ARB_REQ: begin
            mem_rd_req_valid = 1'b1;
            if (grant_id == REQ_DC) begin
               mem_rd_req_addr = dc_rd_req_addr;
               dc_rd_req_ready = mem_rd_req_ready;
            end else begin
               mem_rd_req_addr = ic_rd_req_addr;
               ic_rd_req_ready = mem_rd_req_ready;
            end
            req_hs = mem_rd_req_ready;
            if (req_hs) begin
               state_nxt = ARB_DATA;
            end
         end

         ARB_DATA: begin
            if (grant_id == REQ_DC) begin
               dc_rd_rsp_valid  = mem_rd_rsp_valid;
               dc_rd_rsp_data   = mem_rd_rsp_data;
               dc_rd_rsp_last   = mem_rd_rsp_last;
               mem_rd_rsp_ready = dc_rd_rsp_ready;
            end else begin
               ic_rd_rsp_valid  = mem_rd_rsp_valid;
               ic_rd_rsp_data   = mem_rd_rsp_data;
               ic_rd_rsp_last   = mem_rd_rsp_last;
               mem_rd_rsp_ready = ic_rd_rsp_ready;
            end
            rsp_hs = mem_rd_rsp_valid & mem_rd_rsp_ready;
            // Memory's last flag ends the burst even if the beat count
            // disagrees, so a short burst can never wedge the channel.
            if (rsp_hs && mem_rd_rsp_last) begin
               state_nxt = ARB_IDLE;
            end
         end

         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_id   <= REQ_IC;
         last_grant <= REQ_DC;   // makes the I-cache win the first tie
         beat_cnt   <= '0;
      end else begin
         if (state == ARB_IDLE && pick_win) begin
            grant_id <= pick_id;
         end
         if (req_hs) begin
            beat_cnt <= '0;
         end else if (rsp_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (rsp_hs && mem_rd_rsp_last) begin
            last_grant <= grant_id;
         end
      end
   end

   assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
module tb_mem_rd_arbiter;
   import cache_pkg::*;

   localparam int BL = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ic_rd_req_valid = 1'b0;
   logic [31:0] ic_rd_req_addr  = '0;
   logic        ic_rd_req_ready;
   logic        ic_rd_rsp_valid;
   logic [31:0] ic_rd_rsp_data;
   logic        ic_rd_rsp_last;
   logic        ic_rd_rsp_ready = 1'b1;
   logic        dc_rd_req_valid = 1'b0;
   logic [31:0] dc_rd_req_addr  = '0;
   logic        dc_rd_req_ready;
   logic        dc_rd_rsp_valid;
   logic [31:0] dc_rd_rsp_data;
   logic        dc_rd_rsp_last;
   logic        dc_rd_rsp_ready = 1'b1;
   logic        mem_rd_req_valid;
   logic [31:0] mem_rd_req_addr;
   logic        mem_rd_req_ready = 1'b0;
   logic        mem_rd_rsp_valid = 1'b0;
   logic [31:0] mem_rd_rsp_data  = '0;
   logic        mem_rd_rsp_last  = 1'b0;
   logic        mem_rd_rsp_ready;
   logic        busy;

   mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst),
      .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr),
      .ic_rd_req_ready(ic_rd_req_ready), .ic_rd_rsp_valid(ic_rd_rsp_valid),
      .ic_rd_rsp_data(ic_rd_rsp_data), .ic_rd_rsp_last(ic_rd_rsp_last),
      .ic_rd_rsp_ready(ic_rd_rsp_ready),
      .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr),
      .dc_rd_req_ready(dc_rd_req_ready), .dc_rd_rsp_valid(dc_rd_rsp_valid),
      .dc_rd_rsp_data(dc_rd_rsp_data), .dc_rd_rsp_last(dc_rd_rsp_last),
      .dc_rd_rsp_ready(dc_rd_rsp_ready),
      .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr),
      .mem_rd_req_ready(mem_rd_req_ready), .mem_rd_rsp_valid(mem_rd_rsp_valid),
      .mem_rd_rsp_data(mem_rd_rsp_data), .mem_rd_rsp_last(mem_rd_rsp_last),
      .mem_rd_rsp_ready(mem_rd_rsp_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_ic[$];
   beat_t       exp_dc[$];
   logic [31:0] exp_mem[$];
   logic [31:0] pend_ic[$];
   logic [31:0] pend_dc[$];

   int req_delay   = 2;
   int ic_beats    = 0;
   int ic_stall_at = -1;
   int stall_len   = 0;
   int stall_cnt   = 0;

   // Memory content model: burst at 0x1000 returns 0xA0..0xA7.
   function automatic logic [31:0] beat_data(logic [31:0] a, int i);
      return 32'hA0 + 32'(i) + (a - 32'h1000);
   endfunction

   task automatic issue(input bit port, input logic [31:0] a);
      for (int i = 0; i < BL; i++) begin
         beat_t b;
         b.data = beat_data(a, i);
         b.last = (i == BL - 1);
         if (port) exp_dc.push_back(b);
         else      exp_ic.push_back(b);
      end
      if (port) pend_dc.push_back(a);
      else      pend_ic.push_back(a);
   endtask

   // ---------------- memory model ----------------
   logic        m_busy = 1'b0;
   logic [31:0] m_addr = '0;
   int          m_beat = 0;
   int          m_wait = 0;
   logic        s_req_hs, s_req_vld, s_rsp_hs;
   logic [31:0] s_addr;

   always begin
      @(negedge clk);
      s_req_hs  = mem_rd_req_valid && mem_rd_req_ready;
      s_req_vld = mem_rd_req_valid;
      s_addr    = mem_rd_req_addr;
      s_rsp_hs  = mem_rd_rsp_valid && mem_rd_rsp_ready;
      @(posedge clk);
      #1;
      if (rst) begin
         m_busy = 1'b0; m_beat = 0; m_wait = 0; mem_rd_req_ready = 1'b0;
      end else begin
         if (s_req_hs) begin
            checks++;
            if (exp_mem.size() == 0) begin
               errors++;
               $display("FAIL mem_addr_order: got %h, expected no request", s_addr);
            end else begin
               logic [31:0] e;
               e = exp_mem.pop_front();
               if (s_addr !== e) begin
                  errors++;
                  $display("FAIL mem_addr_order: got %h expected %h", s_addr, e);
               end
            end
            m_busy = 1'b1; m_addr = s_addr; m_beat = 0; m_wait = 0;
            mem_rd_req_ready = 1'b0;
         end else if (s_req_vld && !m_busy) begin
            m_wait++;
            mem_rd_req_ready = (m_wait >= req_delay);
         end
         if (s_rsp_hs) begin
            if (m_beat == BL - 1) m_busy = 1'b0;
            else                  m_beat++;
         end
      end
      mem_rd_rsp_valid = m_busy;
      mem_rd_rsp_data  = m_busy ? beat_data(m_addr, m_beat) : '0;
      mem_rd_rsp_last  = m_busy && (m_beat == BL - 1);
   end

   // ---------------- cache requester models ----------------
   logic s_ic_req_hs, s_dc_req_hs, s_ic_rsp_hs;

   always begin
      @(negedge clk);
      s_ic_req_hs = ic_rd_req_valid && ic_rd_req_ready;
      s_dc_req_hs = dc_rd_req_valid && dc_rd_req_ready;
      s_ic_rsp_hs = ic_rd_rsp_valid && ic_rd_rsp_ready;
      @(posedge clk);
      #1;
      if (rst) begin
         ic_rd_req_valid = 1'b0; dc_rd_req_valid = 1'b0;
         ic_rd_rsp_ready = 1'b1; dc_rd_rsp_ready = 1'b1;
         stall_cnt = 0;
      end else begin
         if (s_ic_req_hs) begin ic_rd_req_valid = 1'b0; void'(pend_ic.pop_front()); end
         if (s_dc_req_hs) begin dc_rd_req_valid = 1'b0; void'(pend_dc.pop_front()); end
         if (!ic_rd_req_valid && pend_ic.size() > 0) begin
            ic_rd_req_valid = 1'b1; ic_rd_req_addr = pend_ic[0];
         end
         if (!dc_rd_req_valid && pend_dc.size() > 0) begin
            dc_rd_req_valid = 1'b1; dc_rd_req_addr = pend_dc[0];
         end
         if (s_ic_rsp_hs) ic_beats++;
         if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) ic_rd_rsp_ready = 1'b1;
         end else if (s_ic_rsp_hs && ic_beats == ic_stall_at) begin
            ic_rd_rsp_ready = 1'b0;
            stall_cnt       = stall_len;
            ic_stall_at     = -1;
         end
      end
   end

   // ---------------- response scoreboard ----------------
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (ic_rd_rsp_valid && ic_rd_rsp_ready) begin
            checks++;
            if (exp_ic.size() == 0) begin
               errors++;
               $display("FAIL ic_beat: got %h, expected no beat", ic_rd_rsp_data);
            end else begin
               beat_t e;
               e = exp_ic.pop_front();
               if ({ic_rd_rsp_data, ic_rd_rsp_last} !== e) begin
                  errors++;
                  $display("FAIL ic_beat: got %h/%b expected %h/%b",
                           ic_rd_rsp_data, ic_rd_rsp_last, e.data, e.last);
               end
            end
         end
         if (dc_rd_rsp_valid && dc_rd_rsp_ready) begin
            checks++;
            if (exp_dc.size() == 0) begin
               errors++;
               $display("FAIL dc_beat: got %h, expected no beat", dc_rd_rsp_data);
            end else begin
               beat_t e;
               e = exp_dc.pop_front();
               if ({dc_rd_rsp_data, dc_rd_rsp_last} !== e) begin
                  errors++;
                  $display("FAIL dc_beat: got %h/%b expected %h/%b",
                           dc_rd_rsp_data, dc_rd_rsp_last, e.data, e.last);
               end
            end
         end
         if (mem_rd_rsp_valid) begin
            // A memory beat is consumed exactly when exactly one cache takes it.
            checks++;
            if ((ic_rd_rsp_valid && dc_rd_rsp_valid) ||
                (mem_rd_rsp_ready !== ((ic_rd_rsp_valid && ic_rd_rsp_ready) ||
                                       (dc_rd_rsp_valid && dc_rd_rsp_ready)))) begin
               errors++;
               $display("FAIL rsp_route: mem_ready=%b ic_v=%b ic_r=%b dc_v=%b dc_r=%b",
                        mem_rd_rsp_ready, ic_rd_rsp_valid, ic_rd_rsp_ready,
                        dc_rd_rsp_valid, dc_rd_rsp_ready);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      rst = 1'b1;
      exp_ic.delete(); exp_dc.delete(); exp_mem.delete();
      pend_ic.delete(); pend_dc.delete();
      req_delay = 2; ic_stall_at = -1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, input bit quiet_dc);
      int  n;
      bit  leak;
      n    = 0;
      leak = 1'b0;
      while (n < budget) begin
         @(negedge clk);
         if (quiet_dc && dc_rd_rsp_valid !== 1'b0) leak = 1'b1;
         if (exp_ic.size() == 0 && exp_dc.size() == 0 && pend_ic.size() == 0 &&
             pend_dc.size() == 0 && !ic_rd_req_valid && !dc_rd_req_valid && !busy) break;
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout: %0d beats ic / %0d dc left, expected 0", name,
                  exp_ic.size(), exp_dc.size());
      end
      checks++;
      if (exp_mem.size() != 0) begin
         errors++;
         $display("FAIL %s_mem_reqs: %0d requests missing, expected 0", name, exp_mem.size());
      end
      if (quiet_dc) begin
         checks++;
         if (leak) begin
            errors++;
            $display("FAIL %s_dc_quiet: dc_rd_rsp_valid seen 1, expected 0", name);
         end
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if ({ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_last, dc_rd_req_ready, dc_rd_rsp_valid,
           dc_rd_rsp_last, mem_rd_req_valid, mem_rd_rsp_ready, busy} !== 9'b0 ||
          ic_rd_rsp_data !== 32'h0 || dc_rd_rsp_data !== 32'h0 || mem_rd_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL %s: busy=%b mem_v=%b mem_addr=%h ic_v=%b dc_v=%b, expected all 0",
                  name, busy, mem_rd_req_valid, mem_rd_req_addr, ic_rd_rsp_valid, dc_rd_rsp_valid);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_quiet("reset_hold");
      rst = 1'b0;
      @(negedge clk);
      check_quiet("reset_release");
   endtask

   task automatic test_single_ic();
      do_reset();
      req_delay = 2;
      exp_mem.push_back(32'h1000);
      issue(1'b0, 32'h1000);
      wait_done("single_ic", 200, 1'b1);
   endtask

   task automatic test_tie();
      int last_cyc, req_cyc, n;
      do_reset();
      last_cyc = -1; req_cyc = -1; n = 0;
      exp_mem.push_back(32'h1000);
      exp_mem.push_back(32'h2000);
      issue(1'b0, 32'h1000);
      issue(1'b1, 32'h2000);
      while (req_cyc < 0 && n < 200) begin
         @(negedge clk);
         if (ic_rd_rsp_valid && ic_rd_rsp_ready && ic_rd_rsp_last) last_cyc = cyc;
         if (mem_rd_req_valid && mem_rd_req_addr == 32'h2000) req_cyc = cyc;
         n++;
      end
      // The last beat completes at the edge after the sample; one idle cycle
      // follows, so the next request is visible two samples later.
      checks++;
      if (last_cyc < 0 || req_cyc - last_cyc != 2) begin
         errors++;
         $display("FAIL tie_gap: dc request %0d samples after ic last (ic last at %0d), expected 2",
                  req_cyc - last_cyc, last_cyc);
      end
      wait_done("tie", 300, 1'b0);
   endtask

   task automatic test_round_robin();
      int n;
      exp_mem.push_back(32'h1000);
      exp_mem.push_back(32'h3000);
      exp_mem.push_back(32'h1000);
      issue(1'b0, 32'h1000);
      issue(1'b0, 32'h1000);
      n = 0;
      while (!busy && n < 50) begin @(negedge clk); n++; end
      issue(1'b1, 32'h3000);
      wait_done("round_robin", 500, 1'b0);
   endtask

   task automatic test_backpressure();
      int stall_seen;
      stall_seen = 0;
      ic_beats = 0; ic_stall_at = 3; stall_len = 3;
      exp_mem.push_back(32'h7000);
      issue(1'b0, 32'h7000);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (busy && !ic_rd_rsp_ready) begin
            stall_seen++;
            checks++;
            if (mem_rd_rsp_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_mem_ready: got %b expected 0", mem_rd_rsp_ready);
            end
         end
         if (exp_ic.size() == 0 && !busy) break;
      end
      checks++;
      if (stall_seen != 3) begin
         errors++;
         $display("FAIL stall_cycles: got %0d expected 3", stall_seen);
      end
      wait_done("backpressure", 100, 1'b1);
   endtask

   task automatic test_async_reset();
      int n;
      ic_beats = 0;
      exp_mem.push_back(32'h1000);
      issue(1'b0, 32'h1000);
      n = 0;
      while (ic_beats < 3 && n < 100) begin @(negedge clk); n++; end
      #2;
      rst = 1'b1;
      #1;
      check_quiet("async_reset");
      exp_ic.delete(); exp_dc.delete(); exp_mem.delete();
      pend_ic.delete(); pend_dc.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_mem.push_back(32'h4000);
      issue(1'b1, 32'h4000);
      wait_done("post_reset_dc", 200, 1'b0);
   endtask

   task automatic test_req_stall();
      int n, stall;
      req_delay = 20;
      exp_mem.push_back(32'h5000);
      exp_mem.push_back(32'h6000);
      issue(1'b0, 32'h5000);
      issue(1'b1, 32'h6000);
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_rd_req_valid && n < 50);
      stall = 0;
      while (!mem_rd_req_ready && stall < 40) begin
         checks++;
         if (mem_rd_req_valid !== 1'b1 || mem_rd_req_addr !== 32'h5000 ||
             ic_rd_req_ready !== 1'b0 || dc_rd_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL req_hold: v=%b addr=%h ic_rdy=%b dc_rdy=%b expected 1/00005000/0/0",
                     mem_rd_req_valid, mem_rd_req_addr, ic_rd_req_ready, dc_rd_req_ready);
         end
         stall++;
         @(negedge clk);
      end
      checks++;
      if (stall != 20 || ic_rd_req_ready !== 1'b1 || dc_rd_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL req_stall_len: %0d cycles ic_rdy=%b dc_rdy=%b expected 20/1/0",
                  stall, ic_rd_req_ready, dc_rd_req_ready);
      end
      wait_done("req_stall", 400, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_ic();
      test_tie();
      test_round_robin();
      test_backpressure();
      test_async_reset();
      test_req_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
